// File: rtl/key_command_encoder.sv
`default_nettype none
// ============================================================================
// Module      : key_command_encoder
// Description : Turns the blackjack board's raw, bouncy, active-low push-button
//               keys into debounced one-shot commands (hit / stand / deal).
//               Commands are offered to the game controller one at a time over
//               a valid/ready handshake. Any press that cannot be delivered is
//               discarded and reported on cmd_dropped.
//               Optional feature macro: KEY_AUTOREPEAT_EN (hit-key auto-repeat
//               every REPEAT_CYCLES clocks while hit stays held).
// Revision    : 1.0 - initial release
// ============================================================================
module key_command_encoder #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4,
    parameter int REPEAT_CYCLES   = 32
) (
    input  logic       clk,
    input  logic       reset,        // asynchronous, active-low
    input  logic [2:0] keys,         // active-low: bit0 hit, bit1 stand, bit2 deal
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic [2:0] key_held,
    output logic       cmd_dropped
);

    localparam logic [1:0] c_code_none  = 2'b00;
    localparam logic [1:0] c_code_hit   = 2'b01;
    localparam logic [1:0] c_code_stand = 2'b10;
    localparam logic [1:0] c_code_deal  = 2'b11;

    // Last sample count before a differing key is accepted as the new level.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Two-flop synchronizer per key. Idle (released) level is 1.
    // ------------------------------------------------------------------------
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;

    // Next state of the synchronizer chain.
    always_comb begin
        sync1_d = keys;
        sync2_d = sync1_q;
    end

    // Synchronizer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // ------------------------------------------------------------------------
    // Per-key debounce: a synced level that differs from the debounced level
    // for DEBOUNCE_CYCLES consecutive samples becomes the new debounced level.
    // Any matching sample restarts the count.
    // ------------------------------------------------------------------------
    logic [2:0] w_deb_lvl;    // current debounced levels (active-low)
    logic [2:0] w_deb_next;   // debounced levels after this edge

    for (genvar k = 0; k < 3; k++) begin : g_key
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             lvl_q, lvl_d;

        // Count consecutive differing samples and accept the new level on the last one.
        always_comb begin
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            if (sync2_q[k] == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == c_cnt_last) begin
                lvl_d = sync2_q[k];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Debounce counter and level registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
                lvl_q <= 1'b1;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign w_deb_lvl[k]  = lvl_q;
        assign w_deb_next[k] = lvl_d;
    end

    // ------------------------------------------------------------------------
    // Press detection: falling edge of the debounced level, one cycle wide.
    // key_held mirrors the debounced level, inverted, on the same edge.
    // ------------------------------------------------------------------------
    logic [2:0] deb_prev_q, deb_prev_d;
    logic [2:0] key_held_q, key_held_d;
    logic [2:0] w_press_key;

    // Track previous debounced level and the registered held indication.
    always_comb begin
        deb_prev_d = w_deb_lvl;
        key_held_d = ~w_deb_next;
    end

    // Edge-history and held registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_prev_q <= 3'b111;
            key_held_q <= 3'b000;
        end else begin
            deb_prev_q <= deb_prev_d;
            key_held_q <= key_held_d;
        end
    end

    assign w_press_key = deb_prev_q & ~w_deb_lvl;

    // ------------------------------------------------------------------------
    // Hit auto-repeat
    // ------------------------------------------------------------------------
    logic w_rep_evt;

`ifdef KEY_AUTOREPEAT_EN
    localparam int c_rep_w = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_CYCLES - 1);

    logic [c_rep_w-1:0] rep_cnt_q, rep_cnt_d;

    // Restart the interval on a real hit press; fire a repeat each interval while held.
    always_comb begin
        rep_cnt_d = '0;
        w_rep_evt = 1'b0;
        if (w_press_key[0]) begin
            rep_cnt_d = '0;
        end else if (!w_deb_lvl[0]) begin
            if (rep_cnt_q == c_rep_last) begin
                w_rep_evt = 1'b1;
                rep_cnt_d = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    // Repeat interval counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    // Auto-repeat compiled out: never any repeat event (constant 0).
    assign w_rep_evt = 1'b0 & (REPEAT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------------
    // Command arbitration and valid/ready handshake
    // ------------------------------------------------------------------------
    logic [2:0] w_events;
    logic [1:0] w_sel_code;
    logic       w_multi;

    assign w_events = w_press_key | {2'b00, w_rep_evt};

    // Pick the winning command (stand > hit > deal) and flag simultaneous presses.
    always_comb begin
        w_sel_code = c_code_none;
        if (w_events[1]) begin
            w_sel_code = c_code_stand;
        end else if (w_events[0]) begin
            w_sel_code = c_code_hit;
        end else if (w_events[2]) begin
            w_sel_code = c_code_deal;
        end
        w_multi = |(w_events & (w_events - 3'd1));
    end

    logic       cmd_valid_q,   cmd_valid_d;
    logic [1:0] cmd_code_q,    cmd_code_d;
    logic       cmd_dropped_q, cmd_dropped_d;

    // Load, hold, consume or drop commands.
    always_comb begin
        cmd_valid_d   = cmd_valid_q;
        cmd_code_d    = cmd_code_q;
        cmd_dropped_d = 1'b0;
        if (|w_events) begin
            if (!cmd_valid_q || cmd_ready) begin
                cmd_valid_d   = 1'b1;
                cmd_code_d    = w_sel_code;
                cmd_dropped_d = w_multi;
            end else begin
                // Slot occupied and not being consumed: held command wins.
                cmd_dropped_d = 1'b1;
            end
        end else if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
            cmd_code_d  = c_code_none;
        end
    end

    // Command output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= c_code_none;
            cmd_dropped_q <= 1'b0;
        end else begin
            cmd_valid_q   <= cmd_valid_d;
            cmd_code_q    <= cmd_code_d;
            cmd_dropped_q <= cmd_dropped_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign key_held    = key_held_q;
    assign cmd_dropped = cmd_dropped_q;

endmodule
`default_nettype wire

// File: doc/key_command_encoder.md
Name: key_command_encoder

Overview:
- Front end for the blackjack game's key inputs.
- Converts the raw, bouncy, active-low push-button keys into single, debounced command events.
- Presents one command at a time to the game controller over a valid/ready handshake.
- Sits between the board keys and blackjackGame's command input, replacing direct key wiring with clean one-shot commands.

Parameters:
- DEBOUNCE_CYCLES, 8, consecutive clk samples a synced key must differ from its debounced level before the new level is accepted (legal range 1..2^CNT_W-1).
- CNT_W, 4, width of each per-key debounce counter.
- REPEAT_CYCLES, 32, hit-key auto-repeat interval in clk cycles (used only with KEY_AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- keys  input  3  raw keys, active-low (0 = pressed): bit0 hit, bit1 stand, bit2 deal card.
- cmd_ready  input  1  game controller accepts cmd_code this edge.
- cmd_valid  output  1  cmd_code holds an unaccepted command.
- cmd_code  output  2  00 none, 01 hit, 10 stand, 11 deal.
- key_held  output  3  debounced key levels, active-high (1 = held), same bit order as keys.
- cmd_dropped  output  1  one-cycle pulse when a detected press is discarded.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync flops = 3'b111; debounced levels = 3'b111 (released); counters = 0.
  - cmd_valid=0, cmd_code=00, key_held=000, cmd_dropped=0.
  - Takes effect immediately and discards any pending command.
- Synchronizer: two flops per key.
- Debounce, per key, each edge:
  - If synced == debounced, counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, debounced <= synced and counter <= 0; else counter <= counter+1.
- Press event: debounced level falls 1->0, detected from the previous debounced value, one cycle wide. Release (0->1) generates no event.
- Latency: keys bit held low from edge 1 → debounced falls at edge DEBOUNCE_CYCLES+2 → cmd_valid=1 after edge DEBOUNCE_CYCLES+3 (11 edges at default).
- Glitch rule: a key low for fewer than DEBOUNCE_CYCLES consecutive synced samples produces nothing; any matching sample restarts the count.
- Simultaneous presses on one edge:
  - Priority stand > hit > deal.
  - Lower-priority events are discarded and cmd_dropped pulses.
- Handshake:
  - cmd_code is stable while cmd_valid=1.
  - cmd_valid=1 && cmd_ready=1 at an edge: the command is consumed. cmd_valid <= 0 and cmd_code <= 00, unless a press event occurs on that same edge, in which case the new command loads and cmd_valid stays 1.
  - Press event while cmd_valid=1 && cmd_ready=0: the press is discarded, cmd_dropped pulses, and the held command is unchanged.
  - cmd_ready while cmd_valid=0: ignored.
- A key held low through reset release produces exactly one command, at DEBOUNCE_CYCLES+3 edges after reset deasserts.
- key_held = ~debounced, registered; no extra latency beyond debounce.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - While hit stays debounced-held, a repeat counter starts at the initial press and generates an additional hit press event every REPEAT_CYCLES cycles.
  - Repeat events follow the same priority, handshake and drop rules as real presses.
  - The counter clears on hit release or reset.
- Undefined:
  - Exactly one command per debounced press; REPEAT_CYCLES is unused and no repeat logic is synthesized.

Test Plan:
- Reset then keys=111 for 50 cycles → cmd_valid=0, key_held=000, cmd_dropped never pulses.
- keys[0]=0 held, cmd_ready=0 → cmd_valid=1, cmd_code=01 after exactly 11 edges; held stable for 20 cycles; cmd_ready=1 for one edge → cmd_valid=0, cmd_code=00 next cycle.
- keys[1] low for 5 cycles with 1-cycle high bounces, then stable low → no command during bounce; cmd_code=10 exactly 11 edges after the last bounce.
- keys[0] and keys[2] fall on the same edge → cmd_code=01, one cmd_dropped pulse; press stand while hit is unaccepted → cmd_dropped pulse, cmd_code stays 01.
- Drive reset=0 mid-debounce and with cmd_valid=1 → outputs clear asynchronously, before the next clk edge; with keys[2] held through reset release → single cmd_code=11 after 11 edges.
- KEY_AUTOREPEAT_EN defined, REPEAT_CYCLES=32, hit held 100 cycles, cmd_ready=1 → hit commands at edges 11, 43, 75, i.e. 3 commands total; undefined → 1 command.
